// File: rtl/pmem_arbiter.sv
// Arbitrates one physical-memory port between I-cache fills and D-cache fills/writebacks.
// D-cache wins by default; a streak counter forces an I grant after MAX_D_STREAK D wins.
module pmem_arbiter #(
   parameter int LINE_WIDTH   = 128,
   parameter int ADDR_WIDTH   = 16,
   parameter int MAX_D_STREAK = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_pmem_read,
   input  logic [ADDR_WIDTH-1:0] i_pmem_address,
   output logic [LINE_WIDTH-1:0] i_pmem_rdata,
   output logic                  i_pmem_resp,
   input  logic                  d_pmem_read,
   input  logic                  d_pmem_write,
   input  logic [ADDR_WIDTH-1:0] d_pmem_address,
   input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
   output logic [LINE_WIDTH-1:0] d_pmem_rdata,
   output logic                  d_pmem_resp,
   output logic                  pmem_read,
   output logic                  pmem_write,
   output logic [ADDR_WIDTH-1:0] pmem_address,
   output logic [LINE_WIDTH-1:0] pmem_wdata,
   input  logic [LINE_WIDTH-1:0] pmem_rdata,
   input  logic                  pmem_resp,
   output logic [1:0]            dbg_state,
   output logic [3:0]            dbg_streak
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GNT_I = 2'd1,
      GNT_D = 2'd2
   } state_t;

   localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

   state_t     state;
   state_t     state_next;
   logic [3:0] streak;
   logic [3:0] streak_next;
   logic       d_req;

   assign d_req = d_pmem_read | d_pmem_write;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         streak <= 4'd0;
      end else begin
         state  <= state_next;
         streak <= streak_next;
      end
   end

   // A dropped request ends the grant early; any late pmem_resp then lands in IDLE and is dropped.
   always_comb begin
      state_next  = state;
      streak_next = streak;
      case (state)
         IDLE: begin
            if (d_req && i_pmem_read)
               state_next = (streak < STREAK_MAX) ? GNT_D : GNT_I;
            else if (d_req)
               state_next = GNT_D;
            else if (i_pmem_read)
               state_next = GNT_I;

            if (!i_pmem_read || state_next == GNT_I)
               streak_next = 4'd0;
            else if (state_next == GNT_D)
               streak_next = (streak >= STREAK_MAX) ? STREAK_MAX : streak + 4'd1;
         end
         GNT_I: begin
            if (!i_pmem_read || pmem_resp)
               state_next = IDLE;
         end
         GNT_D: begin
            if (!d_req || pmem_resp)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      pmem_read    = 1'b0;
      pmem_write   = 1'b0;
      pmem_address = '0;
      pmem_wdata   = '0;
      case (state)
         GNT_I: begin
            pmem_read    = 1'b1;
            pmem_address = i_pmem_address;
         end
         GNT_D: begin
            pmem_read    = d_pmem_read;
            pmem_write   = d_pmem_write;
            pmem_address = d_pmem_address;
            pmem_wdata   = d_pmem_wdata;
         end
         default: ;
      endcase
   end

   assign i_pmem_rdata = pmem_rdata;
   assign d_pmem_rdata = pmem_rdata;
   assign i_pmem_resp  = pmem_resp & (state == GNT_I);
   assign d_pmem_resp  = pmem_resp & (state == GNT_D);
   assign dbg_state    = state;
   assign dbg_streak   = streak;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed bench for pmem_arbiter: grant order, streak limit, reset abort, stray and dropped responses.
module tb_pmem_arbiter;

   localparam int LW = 128;
   localparam int AW = 16;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          i_pmem_read = 1'b0;
   logic [AW-1:0] i_pmem_address = '0;
   logic [LW-1:0] i_pmem_rdata;
   logic          i_pmem_resp;
   logic          d_pmem_read = 1'b0;
   logic          d_pmem_write = 1'b0;
   logic [AW-1:0] d_pmem_address = '0;
   logic [LW-1:0] d_pmem_wdata = '0;
   logic [LW-1:0] d_pmem_rdata;
   logic          d_pmem_resp;
   logic          pmem_read;
   logic          pmem_write;
   logic [AW-1:0] pmem_address;
   logic [LW-1:0] pmem_wdata;
   logic [LW-1:0] pmem_rdata = '0;
   logic          pmem_resp = 1'b0;
   logic [1:0]    dbg_state;
   logic [3:0]    dbg_streak;

   int n_vec = 0;
   int n_err = 0;

   // {read, write, i_resp, d_resp, state}; state IDLE=0, GNT_I=1, GNT_D=2
   logic [5:0] obs;
   assign obs = {pmem_read, pmem_write, i_pmem_resp, d_pmem_resp, dbg_state};

   pmem_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW), .MAX_D_STREAK(4)) dut (
      .clk(clk), .reset(reset),
      .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
      .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
      .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
      .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
      .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
      .pmem_read(pmem_read), .pmem_write(pmem_write),
      .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
      .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
      .dbg_state(dbg_state), .dbg_streak(dbg_streak)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      i_pmem_read = 1'b0; d_pmem_read = 1'b0; d_pmem_write = 1'b0;
      pmem_resp = 1'b0;
      tick(); tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      sample();
      n_vec++;
      if ({obs, dbg_streak, pmem_address} !== '0) begin
         n_err++;
         $display("FAIL reset_state: got %b/%0d/%h want 0", obs, dbg_streak, pmem_address);
      end
      do_reset();
   endtask

   task automatic test_i_only();
      tick(); i_pmem_read = 1'b1; i_pmem_address = 16'h1230;
      sample();
      n_vec++;
      if (obs !== 6'b000000) begin n_err++; $display("FAIL i_latency: got %b want %b", obs, 6'b000000); end
      tick(); sample();
      n_vec++;
      if ({obs, pmem_address} !== {6'b100001, 16'h1230}) begin
         n_err++; $display("FAIL i_grant: got %b/%h want 100001/1230", obs, pmem_address);
      end
      repeat (3) tick();
      pmem_resp = 1'b1; pmem_rdata = {8{16'hBEEF}};
      sample();
      n_vec++;
      if ({obs, i_pmem_rdata} !== {6'b101001, {8{16'hBEEF}}}) begin
         n_err++; $display("FAIL i_resp: got %b/%h want 101001", obs, i_pmem_rdata);
      end
      tick(); pmem_resp = 1'b0; i_pmem_read = 1'b0;
      sample();
      n_vec++;
      if (obs !== 6'b000000) begin n_err++; $display("FAIL i_turnaround: got %b want %b", obs, 6'b000000); end
   endtask

   task automatic test_d_priority();
      do_reset();
      tick();
      i_pmem_read = 1'b1; i_pmem_address = 16'h1111;
      d_pmem_write = 1'b1; d_pmem_address = 16'h4560; d_pmem_wdata = {16{8'hA5}};
      tick(); sample();
      n_vec++;
      if ({obs, pmem_address, pmem_wdata, dbg_streak} !== {6'b010010, 16'h4560, {16{8'hA5}}, 4'd1}) begin
         n_err++; $display("FAIL d_first: got %b/%h/%h/%0d want 010010/4560/a5../1", obs, pmem_address, pmem_wdata, dbg_streak);
      end
      tick(); tick(); pmem_resp = 1'b1;
      sample();
      n_vec++;
      if (obs !== 6'b010110) begin n_err++; $display("FAIL d_resp: got %b want %b", obs, 6'b010110); end
      tick(); pmem_resp = 1'b0; d_pmem_write = 1'b0;
      sample();
      n_vec++;
      if ({obs, dbg_streak} !== {6'b000000, 4'd1}) begin
         n_err++; $display("FAIL d_turnaround: got %b/%0d want 000000/1", obs, dbg_streak);
      end
      tick(); sample();
      n_vec++;
      if ({obs, pmem_address, dbg_streak} !== {6'b100001, 16'h1111, 4'd0}) begin
         n_err++; $display("FAIL i_after_d: got %b/%h/%0d want 100001/1111/0", obs, pmem_address, dbg_streak);
      end
      tick(); pmem_resp = 1'b1;
      tick(); pmem_resp = 1'b0; i_pmem_read = 1'b0;
   endtask

   task automatic test_streak();
      do_reset();
      tick();
      d_pmem_read = 1'b1; d_pmem_address = 16'h3330;
      i_pmem_read = 1'b1; i_pmem_address = 16'h2220;
      for (int k = 1; k <= 4; k++) begin
         tick(); sample();
         n_vec++;
         if ({obs, dbg_streak, pmem_address} !== {6'b100010, 4'(k), 16'h3330}) begin
            n_err++; $display("FAIL streak_d%0d: got %b/%0d/%h want 100010/%0d/3330", k, obs, dbg_streak, pmem_address, k);
         end
         tick(); pmem_resp = 1'b1;
         tick(); pmem_resp = 1'b0;
      end
      tick(); sample();
      n_vec++;
      if ({obs, dbg_streak, pmem_address} !== {6'b100001, 4'd0, 16'h2220}) begin
         n_err++; $display("FAIL streak_i: got %b/%0d/%h want 100001/0/2220", obs, dbg_streak, pmem_address);
      end
      tick(); pmem_resp = 1'b1;
      sample();
      n_vec++;
      if (obs !== 6'b101001) begin n_err++; $display("FAIL streak_iresp: got %b want %b", obs, 6'b101001); end
      tick(); pmem_resp = 1'b0; i_pmem_read = 1'b0;
      tick(); sample();
      n_vec++;
      if ({obs, dbg_streak} !== {6'b100010, 4'd0}) begin
         n_err++; $display("FAIL streak_d_again: got %b/%0d want 100010/0", obs, dbg_streak);
      end
      tick(); pmem_resp = 1'b1;
      tick(); pmem_resp = 1'b0; d_pmem_read = 1'b0;
   endtask

   task automatic test_reset_midflight();
      do_reset();
      tick();
      i_pmem_read = 1'b1; d_pmem_write = 1'b1; d_pmem_address = 16'h5550; d_pmem_wdata = {8{16'h1234}};
      tick(); sample();
      n_vec++;
      if ({obs, dbg_streak} !== {6'b010010, 4'd1}) begin
         n_err++; $display("FAIL rst_pre: got %b/%0d want 010010/1", obs, dbg_streak);
      end
      tick(); pmem_resp = 1'b1; reset = 1'b1;
      sample();
      n_vec++;
      if ({obs, dbg_streak, pmem_address, pmem_wdata} !== '0) begin
         n_err++; $display("FAIL rst_abort: got %b/%0d/%h/%h want 0", obs, dbg_streak, pmem_address, pmem_wdata);
      end
      tick(); pmem_resp = 1'b0; i_pmem_read = 1'b0; d_pmem_write = 1'b0; reset = 1'b0;
   endtask

   task automatic test_stray_resp();
      do_reset();
      tick(); pmem_resp = 1'b1;
      sample();
      n_vec++;
      if (obs !== 6'b000000) begin n_err++; $display("FAIL stray_resp: got %b want %b", obs, 6'b000000); end
      tick(); pmem_resp = 1'b0;
   endtask

   task automatic test_drop();
      do_reset();
      tick(); i_pmem_read = 1'b1; i_pmem_address = 16'h6660;
      tick(); d_pmem_read = 1'b1; d_pmem_address = 16'h7770;
      sample();
      n_vec++;
      if ({obs, pmem_address} !== {6'b100001, 16'h6660}) begin
         n_err++; $display("FAIL drop_grant: got %b/%h want 100001/6660", obs, pmem_address);
      end
      tick(); i_pmem_read = 1'b0;
      tick(); pmem_resp = 1'b1;
      sample();
      n_vec++;
      if (obs !== 6'b000000) begin n_err++; $display("FAIL drop_idle: got %b want %b", obs, 6'b000000); end
      tick(); pmem_resp = 1'b0;
      sample();
      n_vec++;
      if ({obs, pmem_address} !== {6'b100010, 16'h7770}) begin
         n_err++; $display("FAIL drop_d_next: got %b/%h want 100010/7770", obs, pmem_address);
      end
      tick(); pmem_resp = 1'b1;
      tick(); pmem_resp = 1'b0; d_pmem_read = 1'b0;
   endtask

   task automatic test_illegal_rw();
      do_reset();
      tick(); d_pmem_read = 1'b1; d_pmem_write = 1'b1; d_pmem_address = 16'h8880;
      tick(); sample();
      n_vec++;
      if ({obs, pmem_address} !== {6'b110010, 16'h8880}) begin
         n_err++; $display("FAIL illegal_rw: got %b/%h want 110010/8880", obs, pmem_address);
      end
      tick(); pmem_resp = 1'b1;
      tick(); pmem_resp = 1'b0; d_pmem_read = 1'b0; d_pmem_write = 1'b0;
   endtask

   initial begin
      test_reset();
      test_i_only();
      test_d_priority();
      test_streak();
      test_reset_midflight();
      test_stray_resp();
      test_drop();
      test_illegal_rw();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
